// File: rtl/inst_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_pkg
// Shared definitions for the instruction-memory responder slice.
//   RISCV_NOP     : canonical RISC-V NOP (addi x0,x0,0), returned at reset and
//                   for out-of-range fetches
//   imem_state_t  : 1-bit responder state, IMEM_LOAD / IMEM_SERVE
//   PARITY_EN     : 1 when INST_MEM_PARITY_EN is defined
//   IMEM_DATA_W   : stored word width (33 with parity, 32 without)
//   word_parity() : even-parity bit of a 32-bit word
// Configuration macro: INST_MEM_PARITY_EN
// ---------------------------------------------------------------------------
package inst_mem_responder_pkg;

    localparam logic [31:0] RISCV_NOP = 32'h00000013;

    typedef enum logic {
        IMEM_LOAD  = 1'b0,
        IMEM_SERVE = 1'b1
    } imem_state_t;

`ifdef INST_MEM_PARITY_EN
    localparam bit PARITY_EN   = 1'b1;
    localparam int IMEM_DATA_W = 33;
`else
    localparam bit PARITY_EN   = 1'b0;
    localparam int IMEM_DATA_W = 32;
`endif

    // Parity bit stored alongside each word: XOR of all data bits.
    function automatic logic word_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/inst_mem_responder_ram.sv
// ---------------------------------------------------------------------------
// inst_mem_ram
// Single-port synchronous RAM with a registered read port.
//   clk    in  clock
//   we     in  write enable (takes priority over read)
//   re     in  read enable; rdata only changes on a read
//   addr   in  word address, ADDR_W bits
//   wdata  in  write data, WIDTH bits
//   rdata  out registered read data, WIDTH bits
// Parameters: ADDR_W (log2 depth), WIDTH (32, or 33 with parity).
// Contents are never reset.
// ---------------------------------------------------------------------------
module inst_mem_ram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // One access per cycle. A write leaves rdata untouched so the last fetched
    // word stays visible on the read port while the image is being reloaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
// Responder side of the instruction-SRAM fetch interface. Holds a program
// memory of 2**ADDR_W 32-bit words (word addressed) that is filled through a
// streaming load port; fetches are refused (grant low) while loading.
//   clk               in   clock
//   reset             in   synchronous, active-high
//   inst_sram_en      in   fetch read request
//   inst_sram_addr    in   64-bit word address of the fetch
//   inst_sram_rdata   out  fetched instruction, one cycle after acceptance
//   inst_sram_en_toif out  grant: fetches accepted this cycle
//   ld_req            in   pulse in SERVE to start a reload
//   ld_valid          in   load beat valid
//   ld_ready          out  load beat accepted when ld_valid & ld_ready
//   ld_data           in   load word
//   ld_last           in   final beat of the image
//   load_busy         out  high while loading
//   addr_err          out  sticky: an out-of-range fetch occurred
//   par_err           out  sticky parity error (INST_MEM_PARITY_EN only)
// Parameters: ADDR_W, LOAD_ON_RESET (1: leave reset loading), NOP_WORD.
// Configuration macro: INST_MEM_PARITY_EN adds a parity bit per word.
// ---------------------------------------------------------------------------
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int          ADDR_W        = 10,
    parameter int          LOAD_ON_RESET = 1,
    parameter logic [31:0] NOP_WORD      = RISCV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [63:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_en_toif,
    input  logic        ld_req,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        load_busy,
`ifdef INST_MEM_PARITY_EN
    output logic        par_err,
`endif
    output logic        addr_err
);

    localparam imem_state_t RESET_STATE = (LOAD_ON_RESET != 0) ? IMEM_LOAD : IMEM_SERVE;
    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    imem_state_t            state;
    logic [ADDR_W-1:0]      load_cnt;
    logic                   fetch_acc;
    logic                   beat_acc;
    logic                   in_range;
    logic                   rd_from_ram;
    logic                   chk_pending;
    logic                   ram_we;
    logic                   ram_re;
    logic [ADDR_W-1:0]      ram_addr;
    logic [IMEM_DATA_W-1:0] ram_wdata;
    logic [IMEM_DATA_W-1:0] ram_rdata;

    // Handshake qualifiers. The grant and ld_ready are registered with the
    // state, so at most one of these can be true in a given cycle.
    assign fetch_acc = inst_sram_en & inst_sram_en_toif;
    assign beat_acc  = ld_valid & ld_ready;
    assign in_range  = (inst_sram_addr[63:ADDR_W] == '0);

    // FSM with its registered outputs. Grant, ld_ready and load_busy are
    // updated together with the state so they always agree with it. Leaving
    // SERVE clears the load counter; the counter wraps naturally at the top
    // of memory and the load only ends on an accepted ld_last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RESET_STATE;
            inst_sram_en_toif <= (RESET_STATE == IMEM_SERVE);
            ld_ready          <= (RESET_STATE == IMEM_LOAD);
            load_busy         <= (RESET_STATE == IMEM_LOAD);
            load_cnt          <= '0;
        end else begin
            case (state)
                IMEM_SERVE: begin
                    if (ld_req) begin
                        state             <= IMEM_LOAD;
                        inst_sram_en_toif <= 1'b0;
                        ld_ready          <= 1'b1;
                        load_busy         <= 1'b1;
                        load_cnt          <= '0;
                    end
                end
                IMEM_LOAD: begin
                    if (beat_acc) begin
                        load_cnt <= load_cnt + CNT_ONE;
                        if (ld_last) begin
                            state             <= IMEM_SERVE;
                            inst_sram_en_toif <= 1'b1;
                            ld_ready          <= 1'b0;
                            load_busy         <= 1'b0;
                        end
                    end
                end
                default: begin
                    state             <= RESET_STATE;
                    inst_sram_en_toif <= (RESET_STATE == IMEM_SERVE);
                    ld_ready          <= (RESET_STATE == IMEM_LOAD);
                    load_busy         <= (RESET_STATE == IMEM_LOAD);
                    load_cnt          <= '0;
                end
            endcase
        end
    end

    // RAM port steering. Writes only happen in LOAD and reads only in SERVE,
    // so the single port is never contended.
    assign ram_we   = beat_acc;
    assign ram_re   = fetch_acc & in_range;
    assign ram_addr = beat_acc ? load_cnt : inst_sram_addr[ADDR_W-1:0];

`ifdef INST_MEM_PARITY_EN
    assign ram_wdata = {word_parity(ld_data), ld_data};
`else
    assign ram_wdata = ld_data;
`endif

    inst_mem_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (IMEM_DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read-result select and address error. rd_from_ram picks between the
    // RAM's registered output and NOP_WORD; both sources only change on an
    // accepted fetch, so rdata holds whenever nothing is accepted. An
    // out-of-range fetch selects NOP_WORD and latches addr_err until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_from_ram <= 1'b0;
            chk_pending <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            chk_pending <= 1'b0;
            if (fetch_acc) begin
                if (in_range) begin
                    rd_from_ram <= 1'b1;
                    chk_pending <= 1'b1;
                end else begin
                    rd_from_ram <= 1'b0;
                    addr_err    <= 1'b1;
                end
            end
        end
    end

    assign inst_sram_rdata = rd_from_ram ? ram_rdata[31:0] : NOP_WORD;

`ifdef INST_MEM_PARITY_EN
    logic par_sticky;
    logic par_now;

    // The freshly read word is checked in the cycle it appears on rdata; the
    // combinational term makes par_err rise with rdata and the sticky flop
    // keeps it high afterwards.
    assign par_now = chk_pending & (ram_rdata[32] != word_parity(ram_rdata[31:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            par_sticky <= 1'b0;
        end else if (par_now) begin
            par_sticky <= 1'b1;
        end
    end

    assign par_err = par_sticky | par_now;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_responder
// Directed bench for inst_mem_responder. u_dut uses LOAD_ON_RESET=1 and
// covers boot load, fetch, range error, reload with wrap, and (with
// INST_MEM_PARITY_EN) parity. u_dut0 uses LOAD_ON_RESET=0 and covers reset
// during a reload.
// ---------------------------------------------------------------------------
module tb_inst_mem_responder;

    logic        clk;
    int          n_cmp;
    int          n_err;

    // u_dut (LOAD_ON_RESET=1)
    logic        reset;
    logic        en;
    logic [63:0] addr;
    logic [31:0] rdata;
    logic        en_toif;
    logic        ld_req;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        load_busy;
    logic        addr_err;
`ifdef INST_MEM_PARITY_EN
    logic        par_err;
`endif

    // u_dut0 (LOAD_ON_RESET=0)
    logic        reset_b;
    logic        en_b;
    logic [63:0] addr_b;
    logic [31:0] rdata_b;
    logic        en_toif_b;
    logic        ld_req_b;
    logic        ld_valid_b;
    logic        ld_ready_b;
    logic [31:0] ld_data_b;
    logic        ld_last_b;
    logic        load_busy_b;
    logic        addr_err_b;
`ifdef INST_MEM_PARITY_EN
    logic        par_err_b;
`endif

    inst_mem_responder #(
        .ADDR_W        (10),
        .LOAD_ON_RESET (1),
        .NOP_WORD      (32'h00000013)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_en      (en),
        .inst_sram_addr    (addr),
        .inst_sram_rdata   (rdata),
        .inst_sram_en_toif (en_toif),
        .ld_req            (ld_req),
        .ld_valid          (ld_valid),
        .ld_ready          (ld_ready),
        .ld_data           (ld_data),
        .ld_last           (ld_last),
        .load_busy         (load_busy),
`ifdef INST_MEM_PARITY_EN
        .par_err           (par_err),
`endif
        .addr_err          (addr_err)
    );

    inst_mem_responder #(
        .ADDR_W        (10),
        .LOAD_ON_RESET (0),
        .NOP_WORD      (32'h00000013)
    ) u_dut0 (
        .clk               (clk),
        .reset             (reset_b),
        .inst_sram_en      (en_b),
        .inst_sram_addr    (addr_b),
        .inst_sram_rdata   (rdata_b),
        .inst_sram_en_toif (en_toif_b),
        .ld_req            (ld_req_b),
        .ld_valid          (ld_valid_b),
        .ld_ready          (ld_ready_b),
        .ld_data           (ld_data_b),
        .ld_last           (ld_last_b),
        .load_busy         (load_busy_b),
`ifdef INST_MEM_PARITY_EN
        .par_err           (par_err_b),
`endif
        .addr_err          (addr_err_b)
    );

    // 10-time-unit clock; the bench acts 1 unit after each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison point: counts it, and on a miss counts and reports it.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one load beat to u_dut and clock it in.
    task automatic apply_stimulus(input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;  en = 1'b0;  addr = '0;  ld_req = 1'b0;
        ld_valid = 1'b0;  ld_data = '0;  ld_last = 1'b0;
        reset_b = 1'b1;  en_b = 1'b0;  addr_b = '0;  ld_req_b = 1'b0;
        ld_valid_b = 1'b0;  ld_data_b = '0;  ld_last_b = 1'b0;

        step();
        step();
        $display("[TB] reset state");
        check_output("rst_rdata", {32'h0, rdata}, 64'h13);
        check_output("rst_addr_err", {63'h0, addr_err}, 64'h0);
        check_output("rst_en_toif", {63'h0, en_toif}, 64'h0);
        check_output("rst_load_busy", {63'h0, load_busy}, 64'h1);
        check_output("rst_ld_ready", {63'h0, ld_ready}, 64'h1);
        check_output("rst0_en_toif", {63'h0, en_toif_b}, 64'h1);
        check_output("rst0_load_busy", {63'h0, load_busy_b}, 64'h0);
        check_output("rst0_rdata", {32'h0, rdata_b}, 64'h13);
        reset   = 1'b0;
        reset_b = 1'b0;

        // Boot image of four words, last flagged on the fourth beat.
        $display("[TB] boot load");
        for (int i = 0; i < 4; i++) begin
            check_output("boot_en_toif_low", {63'h0, en_toif}, 64'h0);
            apply_stimulus(32'hA0 + 32'(i), i == 3);
        end
        check_output("boot_en_toif_high", {63'h0, en_toif}, 64'h1);
        check_output("boot_load_busy", {63'h0, load_busy}, 64'h0);
        check_output("boot_ld_ready", {63'h0, ld_ready}, 64'h0);

        // Back-to-back fetches, one cycle of latency each.
        $display("[TB] fetch 0..3");
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 64'(i);
            step();
            check_output("fetch_rdata", {32'h0, rdata}, 64'hA0 + 64'(i));
        end
        en = 1'b0;
        step();
        check_output("fetch_hold", {32'h0, rdata}, 64'hA3);

        // Out-of-range fetch returns NOP and latches addr_err.
        $display("[TB] out of range");
        en = 1'b1;  addr = 64'h400;
        step();
        en = 1'b0;
        check_output("oor_rdata", {32'h0, rdata}, 64'h13);
        check_output("oor_addr_err", {63'h0, addr_err}, 64'h1);
        en = 1'b1;  addr = 64'h3;
        step();
        en = 1'b0;
        check_output("inr_rdata", {32'h0, rdata}, 64'hA3);
        check_output("oor_sticky", {63'h0, addr_err}, 64'h1);

        // Reload request alongside a fetch: the fetch still completes.
        $display("[TB] reload with concurrent fetch");
        en = 1'b1;  addr = 64'h1;  ld_req = 1'b1;
        step();
        en = 1'b0;  ld_req = 1'b0;
        check_output("req_fetch_rdata", {32'h0, rdata}, 64'hA1);
        check_output("req_load_busy", {63'h0, load_busy}, 64'h1);
        check_output("req_en_toif", {63'h0, en_toif}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            en = ~en;  addr = 64'h2;
            step();
            check_output("load_rdata_hold", {32'h0, rdata}, 64'hA1);
        end
        en = 1'b0;

        // 1025 beats: the counter wraps and the last beat overwrites word 0.
        $display("[TB] wrapping reload");
        for (int i = 0; i <= 1024; i++) begin
            apply_stimulus(32'hC000_0000 + 32'(i), i == 1024);
        end
        check_output("wrap_en_toif", {63'h0, en_toif}, 64'h1);
        en = 1'b1;  addr = 64'h0;
        step();
        check_output("wrap_word0", {32'h0, rdata}, 64'hC000_0400);
        addr = 64'h1;
        step();
        check_output("wrap_word1", {32'h0, rdata}, 64'hC000_0001);
        addr = 64'h3FF;
        step();
        en = 1'b0;
        check_output("wrap_word1023", {32'h0, rdata}, 64'hC000_03FF);

`ifdef INST_MEM_PARITY_EN
        $display("[TB] parity");
        check_output("par_clean", {63'h0, par_err}, 64'h0);
        u_dut.u_ram.mem[2][32] = ~u_dut.u_ram.mem[2][32];
        en = 1'b1;  addr = 64'h2;
        step();
        en = 1'b0;
        check_output("par_rdata", {32'h0, rdata}, 64'hC000_0002);
        check_output("par_err_set", {63'h0, par_err}, 64'h1);
        step();
        check_output("par_err_sticky", {63'h0, par_err}, 64'h1);
`endif

        // u_dut0: full image A0..A3, then a reload cut short by reset.
        $display("[TB] reset during reload");
        ld_req_b = 1'b1;
        step();
        ld_req_b = 1'b0;
        check_output("b_load_busy", {63'h0, load_busy_b}, 64'h1);
        for (int i = 0; i < 4; i++) begin
            ld_valid_b = 1'b1;  ld_data_b = 32'hA0 + 32'(i);  ld_last_b = (i == 3);
            step();
        end
        ld_valid_b = 1'b0;  ld_last_b = 1'b0;
        ld_req_b = 1'b1;
        step();
        ld_req_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid_b = 1'b1;  ld_data_b = 32'hB0 + 32'(i);
            step();
        end
        ld_valid_b = 1'b0;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        check_output("b_rst_en_toif", {63'h0, en_toif_b}, 64'h1);
        check_output("b_rst_load_busy", {63'h0, load_busy_b}, 64'h0);
        en_b = 1'b1;
        addr_b = 64'h0;
        step();
        check_output("b_word0", {32'h0, rdata_b}, 64'hB0);
        addr_b = 64'h1;
        step();
        check_output("b_word1", {32'h0, rdata_b}, 64'hB1);
        addr_b = 64'h2;
        step();
        en_b = 1'b0;
        check_output("b_word2", {32'h0, rdata_b}, 64'hA2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
